// File: rtl/dat_mem_pkg.sv
// dat_mem_pkg: shared defaults, stack operation encoding and the push/pop decode
// helper used by dat_mem_stk and its stack controller.
package dat_mem_pkg;

  localparam int DW_DEF        = 8;
  localparam int AW_DEF        = 8;
  localparam int STK_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    STK_NONE = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2,
    STK_REPL = 2'd3
  } stk_op_t;

  typedef struct packed {
    stk_op_t op;
    logic    ovf_ev;
    logic    unf_ev;
  } stk_dec_t;

  // Push+pop on an empty stack degrades to a plain push; blocked ops raise events only.
  function automatic stk_dec_t stk_decode(input logic push, input logic pop,
                                          input logic empty, input logic full);
    stk_dec_t dec;
    dec.op     = STK_NONE;
    dec.ovf_ev = 1'b0;
    dec.unf_ev = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (full) dec.ovf_ev = 1'b1;
        else      dec.op     = STK_PUSH;
      end
      2'b01: begin
        if (empty) dec.unf_ev = 1'b1;
        else       dec.op     = STK_POP;
      end
      2'b11: begin
        if (empty) dec.op = STK_PUSH;
        else       dec.op = STK_REPL;
      end
      default: dec.op = STK_NONE;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/dat_mem_stk_ctrl.sv
// stk_ctrl: stack occupancy counter, full/empty decode, sticky error flags and
// the stack write address/enable for the downward-growing stack region.
module stk_ctrl
  import dat_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic [AW:0]   stk_cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  output logic          stk_we,
  output logic [AW-1:0] stk_waddr,
  output logic [AW-1:0] top_addr
);

  localparam logic [AW:0] TOP_W   = (AW+1)'((2**AW) - 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(STK_DEPTH);
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  logic [AW:0] cnt_r;
  logic        ovf_r;
  logic        unf_r;
  logic [AW:0] free_s;
  logic [AW:0] top_s;
  stk_dec_t    dec_s;

  assign empty   = (cnt_r == {(AW+1){1'b0}});
  assign full    = (cnt_r == DEPTH_W);
  assign stk_cnt = cnt_r;
  assign ovf     = ovf_r;
  assign unf     = unf_r;
  assign dec_s   = stk_decode(push, pop, empty, full);

  // Computed one bit wider so an empty stack's top wraps harmlessly past the array end.
  assign free_s   = TOP_W - cnt_r;
  assign top_s    = free_s + ONE_W;
  assign top_addr = top_s[AW-1:0];

  // Stack write port: push fills the next free slot, replace overwrites the top.
  always_comb begin
    stk_we    = 1'b0;
    stk_waddr = free_s[AW-1:0];
    case (dec_s.op)
      STK_PUSH: begin
        stk_we    = 1'b1;
        stk_waddr = free_s[AW-1:0];
      end
      STK_REPL: begin
        stk_we    = 1'b1;
        stk_waddr = top_s[AW-1:0];
      end
      default: begin
        stk_we    = 1'b0;
        stk_waddr = free_s[AW-1:0];
      end
    endcase
  end

  // Occupancy counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {(AW+1){1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      case (dec_s.op)
        STK_PUSH: cnt_r <= cnt_r + ONE_W;
        STK_POP:  cnt_r <= cnt_r - ONE_W;
        default:  cnt_r <= cnt_r;
      endcase
      ovf_r <= ovf_r | dec_s.ovf_ev;
      unf_r <= unf_r | dec_s.unf_ev;
    end
  end

endmodule

// File: rtl/dat_mem_stk.sv
// dat_mem_stk: 2**AW x DW data memory with a load/store port and a hardware stack
// at the top of the array. Define DAT_MEM_RDREG_EN for a registered dat_out.
module dat_mem_stk
  import dat_mem_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] stk_top,
  output logic [AW:0]   stk_cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  output logic          wr_clash
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic          stk_we_s;
  logic [AW-1:0] stk_waddr_s;
  logic [AW-1:0] top_addr_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;

  stk_ctrl #(
    .AW        (AW),
    .STK_DEPTH (STK_DEPTH)
  ) u_stk_ctrl (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .stk_cnt   (stk_cnt),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf),
    .stk_we    (stk_we_s),
    .stk_waddr (stk_waddr_s),
    .top_addr  (top_addr_s)
  );

  // Any stack request, even a blocked one, pre-empts the store.
  assign wr_clash = wr_en & (push | pop);

  // Single array write port: stack traffic first, then plain stores.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = addr;
    if (stk_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = stk_waddr_s;
    end else if (wr_en && !push && !pop) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = addr;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = addr;
    end
  end

  // Array storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_r[mem_waddr_s] <= dat_in;
  end

  // Top-of-stack view reads zero while the stack is empty.
  always_comb begin
    stk_top = {DW{1'b0}};
    if (empty) stk_top = {DW{1'b0}};
    else       stk_top = mem_r[top_addr_s];
  end

`ifdef DAT_MEM_RDREG_EN
  // Registered read samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dat_out <= {DW{1'b0}};
    else       dat_out <= mem_r[addr];
  end
`else
  assign dat_out = mem_r[addr];
`endif

endmodule
